// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter and IDLE/ACCESS/DONE sequencer for the single-port data memory
// DMEM_ARB_RR_EN selects round-robin arbitration; fixed A-over-B priority otherwise.
module dmem_arbiter #(
    parameter int MEM_WORDS = 32,
    parameter int AW        = 32
) (
    input  logic          CLK,
    input  logic          RST_n,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [31:0]   a_wdata,
    output logic          a_ack,
    output logic          a_err,
    output logic [31:0]   a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [31:0]   b_wdata,
    output logic          b_ack,
    output logic          b_err,
    output logic [31:0]   b_rdata,
    output logic          busy,
    output logic [AW-1:0] mem_DAddr,
    output logic [31:0]   mem_DataIn,
    output logic          mem_RD,
    output logic          mem_WR,
    input  logic [31:0]   mem_DataOut
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [AW-1:0] ADDR_LIMIT = AW'(MEM_WORDS);

    state_t        state, state_next;
    logic          grant_b;
    logic          winner_b;
    logic          lat_we;
    logic          lat_err;
    logic          sel_we;
    logic          sel_oor;
    logic [AW-1:0] sel_addr;
    logic [31:0]   sel_wdata;

`ifdef DMEM_ARB_RR_EN
    // rr_ptr = 1 means B wins the next tie
    logic rr_ptr;
`endif

    always_comb begin
        state_next = state;
`ifdef DMEM_ARB_RR_EN
        grant_b = b_req && (!a_req || rr_ptr);
`else
        grant_b = b_req && !a_req;
`endif
        sel_we    = grant_b ? b_we    : a_we;
        sel_addr  = grant_b ? b_addr  : a_addr;
        sel_wdata = grant_b ? b_wdata : a_wdata;
        sel_oor   = (sel_addr >= ADDR_LIMIT);
        case (state)
            IDLE:    if (a_req || b_req) state_next = ACCESS;
            ACCESS:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            winner_b   <= 1'b0;
            lat_we     <= 1'b0;
            lat_err    <= 1'b0;
            a_ack      <= 1'b0;
            a_err      <= 1'b0;
            a_rdata    <= '0;
            b_ack      <= 1'b0;
            b_err      <= 1'b0;
            b_rdata    <= '0;
            busy       <= 1'b0;
            mem_DAddr  <= '0;
            mem_DataIn <= '0;
            mem_RD     <= 1'b1;
            mem_WR     <= 1'b1;
`ifdef DMEM_ARB_RR_EN
            rr_ptr     <= 1'b0;
`endif
        end else begin
            a_ack <= 1'b0;
            a_err <= 1'b0;
            b_ack <= 1'b0;
            b_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        winner_b   <= grant_b;
                        lat_we     <= sel_we;
                        lat_err    <= sel_oor;
                        mem_DAddr  <= sel_addr;
                        mem_DataIn <= sel_wdata;
                        busy       <= 1'b1;
                        // Out-of-range requests still take the ACCESS slot but never strobe
                        if (!sel_oor) begin
                            if (sel_we) mem_WR <= 1'b0;
                            else        mem_RD <= 1'b0;
                        end
`ifdef DMEM_ARB_RR_EN
                        rr_ptr     <= !grant_b;
`endif
                    end
                end
                ACCESS: begin
                    mem_RD <= 1'b1;
                    mem_WR <= 1'b1;
                    if (!lat_err && !lat_we) begin
                        if (winner_b) b_rdata <= mem_DataOut;
                        else          a_rdata <= mem_DataOut;
                    end
                    a_ack <= !winner_b;
                    b_ack <= winner_b;
                    a_err <= !winner_b && lat_err;
                    b_err <= winner_b && lat_err;
                end
                DONE: begin
                    busy <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
